// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter that owns the select of a 4-input datapath mux.
// One requester is granted at a time. The selected operand is registered
// onto a shared output bus together with a valid flag. A waiting requester
// gets the bus after at most MAX_HOLD consecutive cycles of another owner.
module mux4_rr_arbiter #(
  parameter int WIDTH    = 16,
  parameter int MAX_HOLD = 8    // legal range 2..255
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic [WIDTH-1:0] in4,
  output logic [3:0]       grant,
  output logic [1:0]       select,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             busy
);

  typedef enum logic {IDLE, GRANT} state_e;

  // The owner keeps the bus until hold_cnt reaches this value while others wait.
  localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD - 1);

  state_e           state_q, state_d;
  logic [1:0]       owner_q, owner_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [7:0]       hold_q, hold_d;
  logic [3:0]       grant_q, grant_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             valid_q, valid_d;

  logic [3:0]       others;
  logic [WIDTH-1:0] sel_data;

  // Returns the first requesting index, scanning start, start+1, ... (mod 4).
  function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] start);
    logic [1:0] idx;
    pick = start;
    // Scan from the farthest offset down, so the nearest requester wins.
    for (int i = 3; i >= 0; i--) begin
      idx = start + 2'(i);
      if (r[idx]) pick = idx;
    end
  endfunction

  // Operand currently routed through the shared mux.
  always_comb begin
    unique case (owner_q)
      2'd0:    sel_data = in1;
      2'd1:    sel_data = in2;
      2'd2:    sel_data = in3;
      default: sel_data = in4;
    endcase
  end

  // Arbitration and data-path next state.
  always_comb begin
    // NOTE: every variable gets a default first, so no path can infer a latch.
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    out_d   = out_q;
    valid_d = 1'b0;
    others  = req & ~(4'b0001 << owner_q);

    unique case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = GRANT;
          owner_d = pick(req, ptr_q);
          hold_d  = '0;
        end
      end
      GRANT: begin
        if (!req[owner_q]) begin
          // Owner released: it drops to lowest priority.
          ptr_d = owner_q + 2'd1;
          if (|others) begin
            owner_d = pick(others, owner_q + 2'd1);
            hold_d  = '0;
          end else begin
            state_d = IDLE;
          end
        end else if (hold_q == HOLD_LIMIT && |others) begin
          // Forced rotation: the owner has held the bus long enough.
          ptr_d   = owner_q + 2'd1;
          owner_d = pick(others, owner_q + 2'd1);
          hold_d  = '0;
        end else if (hold_q != HOLD_LIMIT) begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    grant_d = (state_d == GRANT) ? (4'b0001 << owner_d) : 4'b0000;

    // Capture the owner's operand only while it is still requesting.
    if (state_q == GRANT && req[owner_q]) begin
      out_d   = sel_data;
      valid_d = 1'b1;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
      grant_q <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so every flop samples pre-edge values.
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      grant_q <= grant_d;
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end

  assign grant     = grant_q;
  assign select    = owner_q;
  assign out       = out_q;
  assign out_valid = valid_q;
  assign busy      = (state_q == GRANT);

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter. Each step drives inputs and queues the
// outputs expected after the next rising edge. It then pops and compares them.
module tb_mux4_rr_arbiter;

  localparam int WIDTH    = 16;
  localparam int MAX_HOLD = 8;

  logic             clock;
  logic             reset;
  logic [3:0]       req;
  logic [WIDTH-1:0] in1, in2, in3, in4;
  logic [3:0]       grant;
  logic [1:0]       select;
  logic [WIDTH-1:0] out;
  logic             out_valid;
  logic             busy;

  typedef struct packed {
    logic [3:0]       grant;
    logic [1:0]       sel;
    logic             valid;
    logic [WIDTH-1:0] out;
    logic             busy;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  mux4_rr_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .in1       (in1),
    .in2       (in2),
    .in3       (in3),
    .in4       (in4),
    .grant     (grant),
    .select    (select),
    .out       (out),
    .out_valid (out_valid),
    .busy      (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Watchdog: the run must never hang.
  initial begin
    #200000;
    $display("FAIL timeout: run still active at %0t, required finish", $time);
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: got %h, required %h", tag, obs, expv);
    end
  endtask

  // Drive one cycle of stimulus, queue its expected outputs, check after the edge.
  task automatic step(input logic rst, input logic [3:0] r,
                      input logic [3:0] g, input logic [1:0] s,
                      input logic v, input logic [WIDTH-1:0] o, input logic b);
    exp_t e;
    reset = rst;
    req   = r;
    exp_q.push_back('{grant: g, sel: s, valid: v, out: o, busy: b});
    @(posedge clock);
    #1;
    e = exp_q.pop_front();
    chk("grant",     WIDTH'(grant),     WIDTH'(e.grant));
    chk("select",    WIDTH'(select),    WIDTH'(e.sel));
    chk("out_valid", WIDTH'(out_valid), WIDTH'(e.valid));
    chk("out",       out,               e.out);
    chk("busy",      WIDTH'(busy),      WIDTH'(e.busy));
  endtask

  logic [WIDTH-1:0] data [4];
  logic [WIDTH-1:0] prev;

  initial begin
    data[0] = 16'h0061; data[1] = 16'h0062; data[2] = 16'h0063; data[3] = 16'h0064;
    in1 = data[0]; in2 = data[1]; in3 = data[2]; in4 = data[3];
    reset = 1'b1;
    req   = 4'b0000;

    // Reset state; requests are ignored while reset is high.
    step(1, 4'b1111, 4'b0000, 2'd0, 0, 16'h0000, 0);
    step(1, 4'b1111, 4'b0000, 2'd0, 0, 16'h0000, 0);

    // Single request: grant after one edge, data after the next.
    step(0, 4'b0001, 4'b0001, 2'd0, 0, 16'h0000, 1);
    step(0, 4'b0001, 4'b0001, 2'd0, 1, 16'h0061, 1);

    // Release to idle: out holds, select unchanged, ptr becomes 1.
    step(0, 4'b0000, 4'b0000, 2'd0, 0, 16'h0061, 0);
    step(0, 4'b1000, 4'b1000, 2'd3, 0, 16'h0061, 1);
    step(0, 4'b1000, 4'b1000, 2'd3, 1, 16'h0064, 1);
    step(0, 4'b0000, 4'b0000, 2'd3, 0, 16'h0064, 0);   // ptr now 0

    // Handover with no bubble: in1 owns, drops while 1100 waits.
    step(0, 4'b0001, 4'b0001, 2'd0, 0, 16'h0064, 1);
    step(0, 4'b1101, 4'b0001, 2'd0, 1, 16'h0061, 1);
    step(0, 4'b1100, 4'b0100, 2'd2, 0, 16'h0061, 1);   // ptr=1 -> pick in3
    step(0, 4'b1100, 4'b0100, 2'd2, 1, 16'h0063, 1);
    step(0, 4'b1000, 4'b1000, 2'd3, 0, 16'h0063, 1);   // ptr=3 -> pick in4
    step(0, 4'b1000, 4'b1000, 2'd3, 1, 16'h0064, 1);
    step(0, 4'b0000, 4'b0000, 2'd3, 0, 16'h0064, 0);   // ptr now 0

    // Lone hog for 20 cycles: no rotation, hold count saturates.
    step(0, 4'b0100, 4'b0100, 2'd2, 0, 16'h0064, 1);
    for (int i = 1; i < 20; i++)
      step(0, 4'b0100, 4'b0100, 2'd2, 1, 16'h0063, 1);
    // Saturated count forces rotation on the first edge a rival appears.
    step(0, 4'b0101, 4'b0001, 2'd0, 1, 16'h0063, 1);
    step(0, 4'b0000, 4'b0000, 2'd0, 0, 16'h0063, 0);   // ptr now 1

    // Reset mid-grant of in3.
    step(0, 4'b0100, 4'b0100, 2'd2, 0, 16'h0063, 1);
    step(0, 4'b0100, 4'b0100, 2'd2, 1, 16'h0063, 1);
    step(1, 4'b0100, 4'b0000, 2'd0, 0, 16'h0000, 0);

    // Full contention from ptr=0: each owner holds exactly MAX_HOLD cycles.
    step(0, 4'b1111, 4'b0001, 2'd0, 0, 16'h0000, 1);
    prev = data[0];
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < MAX_HOLD; j++) begin
        if (k == 0 && j == 0) continue;
        step(0, 4'b1111, 4'b0001 << k, 2'(k), 1, (j == 0) ? prev : data[k], 1);
      end
      prev = data[k];
    end
    step(0, 4'b1111, 4'b0001, 2'd0, 1, 16'h0064, 1);
    step(0, 4'b1111, 4'b0001, 2'd0, 1, 16'h0061, 1);
    step(0, 4'b0000, 4'b0000, 2'd0, 0, 16'h0061, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
